// File: rtl/multitim.sv
// multitim: NUM_CH independent programmable down-counter timers behind a
// byte-wide register bus. Each channel has a reload value, a control word
// (periodic, irq_en), a busy flag, a sticky expired flag and a snapshot
// register. irq is the registered OR of expired & irq_en over all channels.
//
// Bus protocol: a cycle with cs_n=0, rd_n=0, wr_n=1 is a read and data_out is
// driven combinationally for as long as it lasts; a cycle with cs_n=0,
// rd_n=1, wr_n=0 performs exactly one register write per rising clock edge.
// Any other strobe combination is idle.
//
// Register map per channel (addr[5:4] = channel, addr[3:0] = offset):
//   0..3  RELOAD byte 0..3   R/W (bytes >= CNT_BYTES read 0, writes ignored)
//   4     CTRL               R/W bit0 periodic, bit1 irq_en
//   5     STATUS             R bit0 busy, bit1 expired; W1C bit1
//   6     CMD                W bit0 start, bit1 stop, bit2 snapshot; reads 0
//   8..11 SNAP byte 0..3     R
module multitim #(
    parameter int NUM_CH    = 2,
    parameter int CNT_BYTES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [5:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       irq
);

    localparam int CNT_W = 8 * CNT_BYTES;

    // Per-channel FSM encoding; busy is simply "state == ST_RUN".
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] OFF_CTRL   = 4'd4;
    localparam logic [3:0] OFF_STATUS = 4'd5;
    localparam logic [3:0] OFF_CMD    = 4'd6;

    logic              read_sel;
    logic              write_sel;
    logic [1:0]        ch_idx;
    logic [3:0]        offset;
    logic [NUM_CH-1:0] expired_v;
    logic [NUM_CH-1:0] irq_en_v;
    logic [NUM_CH-1:0] run_state;   // per-channel FSM state, for observation
    logic [7:0]        rd_data [NUM_CH];

    assign read_sel  = !cs_n && !rd_n &&  wr_n;
    assign write_sel = !cs_n &&  rd_n && !wr_n;
    assign ch_idx    = addr[5:4];
    assign offset    = addr[3:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [0:0]       state;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] reload;
        logic [CNT_W-1:0] snap;
        logic             periodic;
        logic             irq_en;
        logic             expired;
        logic             sel_wr;
        logic             do_start;
        logic             do_stop;
        logic             do_snap;
        logic             do_clr;
        logic             terminal;
        logic             set_exp;
        logic [31:0]      reload_32;
        logic [31:0]      snap_32;
        logic [7:0]       rd_byte;

        // Channel index never exceeds NUM_CH-1 here, so writes aimed at
        // missing channels simply match no channel and are dropped.
        assign sel_wr   = write_sel && (ch_idx == 2'(g));
        assign do_stop  = sel_wr && (offset == OFF_CMD) && data_in[1];
        // Stop takes priority over a start carried in the same write.
        assign do_start = sel_wr && (offset == OFF_CMD) && data_in[0] && !data_in[1];
        assign do_snap  = sel_wr && (offset == OFF_CMD) && data_in[2];
        assign do_clr   = sel_wr && (offset == OFF_STATUS) && data_in[1];
        assign terminal = (state == ST_RUN) && (cnt == '0);
        // A start or stop landing on the terminal edge suppresses the expiry.
        assign set_exp  = terminal && !do_start && !do_stop;

        // Zero-extended views so byte lanes above CNT_BYTES read as 0.
        assign reload_32 = 32'(reload);
        assign snap_32   = 32'(snap);

        // Configuration registers: reload byte lanes and control bits.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                reload   <= '0;
                periodic <= 1'b0;
                irq_en   <= 1'b0;
            end else if (sel_wr) begin
                for (int b = 0; b < CNT_BYTES; b++) begin
                    if (offset == 4'(b)) begin
                        reload[8*b +: 8] <= data_in;
                    end
                end
                if (offset == OFF_CTRL) begin
                    periodic <= data_in[0];
                    irq_en   <= data_in[1];
                end
            end
        end

        // Counter FSM: stop > start > run-time count/reload/finish.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (do_stop) begin
                state <= ST_IDLE;
            end else if (do_start) begin
                cnt   <= reload;
                state <= ST_RUN;
            end else if (state == ST_RUN) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNT_W'(1);
                end else if (periodic) begin
                    cnt <= reload;
                end else begin
                    state <= ST_IDLE;
                end
            end
        end

        // Sticky expired flag: setting on terminal beats a same-edge clear.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                expired <= 1'b0;
            end else if (set_exp) begin
                expired <= 1'b1;
            end else if (do_clr) begin
                expired <= 1'b0;
            end
        end

        // Snapshot captures the counter value present before this edge.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                snap <= '0;
            end else if (do_snap) begin
                snap <= cnt;
            end
        end

        // Per-channel read data for the addressed offset.
        always_comb begin
            rd_byte = 8'h00;
            case (offset)
                4'd0, 4'd1, 4'd2, 4'd3:
                    rd_byte = reload_32[{offset[1:0], 3'b000} +: 8];
                OFF_CTRL:
                    rd_byte = {6'b0, irq_en, periodic};
                OFF_STATUS:
                    rd_byte = {6'b0, expired, (state == ST_RUN)};
                4'd8, 4'd9, 4'd10, 4'd11:
                    rd_byte = snap_32[{offset[1:0], 3'b000} +: 8];
                default:
                    rd_byte = 8'h00;
            endcase
        end

        assign rd_data[g]   = rd_byte;
        assign expired_v[g] = expired;
        assign irq_en_v[g]  = irq_en;
        assign run_state[g] = (state == ST_RUN);
    end

    // Read mux: only a live read of an existing channel produces data.
    always_comb begin
        data_out = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (read_sel && (ch_idx == 2'(i))) begin
                data_out = rd_data[i];
            end
        end
    end

    // Registered interrupt request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(expired_v & irq_en_v);
        end
    end

endmodule

// File: doc/multitim.md
MULTITIM -- requirements
Module: multitim

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent timer channels (legal 1..4).
REQ-002 Parameter CNT_BYTES, default 4, counter width in bytes (legal 1..4); CNT_W = 8*CNT_BYTES.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cs_n  input  1  chip select, active low.
REQ-006 rd_n  input  1  read strobe, active low.
REQ-007 wr_n  input  1  write strobe, active low.
REQ-008 addr  input  6  addr[5:4] channel index, addr[3:0] register offset.
REQ-009 data_in  input  8  write data.
REQ-010 data_out  output  8  read data, combinational.
REQ-011 irq  output  1  OR over channels of (expired & irq_en), registered.

Function
REQ-012 read_sel = !cs_n & rd_n==0 & wr_n==1; write_sel = !cs_n & rd_n==1 & wr_n==0; each rising edge with write_sel high performs exactly one register write.
REQ-013 Per-channel offsets: 0..3 RELOAD byte 0..3 (R/W); 4 CTRL (R/W: bit0 periodic, bit1 irq_en, others read 0); 5 STATUS (R: bit0 busy, bit1 expired; W: write 1 to bit1 clears expired); 6 CMD (W-only, bit0 start, bit1 stop, bit2 snapshot; reads 0); 8..11 SNAP byte 0..3 (R-only).
REQ-014 data_out SHALL be 0 when read_sel is low, when channel index >= NUM_CH, for unmapped offsets, and for RELOAD/SNAP bytes >= CNT_BYTES.
REQ-015 Writes to channel index >= NUM_CH or to byte lanes >= CNT_BYTES SHALL be ignored.
REQ-016 Each channel holds a CNT_W-bit down-counter cnt, busy flag, sticky expired flag, CNT_W-bit snap register.
REQ-017 States per channel: IDLE (busy=0) and RUN (busy=1).
REQ-018 CMD start in any state: cnt <= RELOAD, busy <= 1 on the same edge; restart while RUN reloads without setting expired.
REQ-019 RUN with cnt != 0: cnt decrements by 1 per clock.
REQ-020 RUN with cnt == 0 (terminal): expired <= 1; if periodic, cnt <= RELOAD and stay RUN; else busy <= 0, cnt holds 0.
REQ-021 Period from start edge to expired set is RELOAD+1 clocks; periodic RELOAD=0 expires every clock.
REQ-022 CMD stop: busy <= 0, cnt holds value; expired unchanged.
REQ-023 start and stop in same write: stop wins.
REQ-024 start coinciding with terminal: start wins, expired not set that cycle.
REQ-025 expired write-1-clear coinciding with terminal expiry: set wins.
REQ-026 CMD snapshot: snap <= current cnt (pre-decrement value) on that edge; may combine with start (snap takes old cnt).
REQ-027 RELOAD write during RUN affects only the next load; cnt unaffected.
REQ-028 irq <= |(expired[i] & irq_en[i]), one-cycle registered latency after expired or irq_en changes.
REQ-029 Channels SHALL be fully independent; no cross-channel interaction except irq OR.

Reset
REQ-030 reset_n low SHALL asynchronously clear cnt, RELOAD, CTRL, busy, expired, snap for all channels and irq to 0; data_out follows REQ-014.
REQ-031 Reset mid-RUN SHALL abort the channel to IDLE; after release no expiry occurs until a new start.

Verification
REQ-032 Ch0 RELOAD=5, one-shot, start -> busy=1; expired=1 and busy=0 exactly 6 clocks after start edge; cnt stays 0.
REQ-033 Ch1 RELOAD=3, periodic, irq_en=1 -> expired every 4 clocks, irq=1 one clock after first expiry; write STATUS=0x02 at an expiry edge -> expired remains 1.
REQ-034 CNT_BYTES=2: write RELOAD byte 2 = 0xAA -> reads 0; RELOAD=0xFFFF one-shot -> expiry after 65536 clocks.
REQ-035 Ch0 running at cnt=0x10, CMD=0x04 -> SNAP0 reads 0x10, SNAP1..3 read 0; CMD=0x03 -> busy=0, cnt held.
REQ-036 Both channels running, reset_n pulsed low mid-count -> all registers 0, irq=0, no expiry after release without start.
REQ-037 Read addr channel 3 with NUM_CH=2 and offset 7 on ch0 -> data_out=0x00; writes there change no state.
